kavach_adc_sequencer: RTL and testbench
=======================================

// Module: kavach_adc_sequencer
// PURPOSE
//   Producer side of the Kavach VDD/IDD sample interface. Paces an on-chip ADC
//   (start/done handshake), converts VDD (chan 0) then IDD (chan 1) per tick,
//   and emits the pair as vdd_sample/idd_sample with a one-cycle sample_valid
//   strobe to the power monitor. Flags ADC timeouts and dropped (overrun) ticks.
// PARAMETERS
//   ADC_WIDTH     12       sample width; also width of adc_data
//   RATE_DIV      16'd100  clk cycles per sample-pair tick; legal range 2..65535
//   CONV_TIMEOUT  8'd64    max cycles in CONV awaiting adc_done; legal range 1..255
//   OVS_LOG2      2        log2 conversions averaged per channel (OVS build only)
// PORTS
//   clk          in   1          system clock
//   rst          in   1          reset
//   enable       in   1          1 = run sequencer
//   adc_start    out  1          one-cycle conversion start pulse
//   adc_chan     out  1          channel select: 0=VDD, 1=IDD; stable start->done
//   adc_done     in   1          conversion complete, adc_data valid this cycle
//   adc_data     in   ADC_WIDTH  conversion result
//   vdd_sample   out  ADC_WIDTH  latest VDD result, held between pairs
//   idd_sample   out  ADC_WIDTH  latest IDD result, held between pairs
//   sample_valid out  1          one-cycle strobe, new pair on outputs
//   seq_busy     out  1          1 when state is neither IDLE nor WAIT_TICK
//   timeout_err  out  1          sticky ADC timeout flag
//   timeout_clr  in   1          clears timeout_err
//   overrun_cnt  out  8          dropped-tick count, saturates at 255
//   pair_cnt     out  16         published pairs, wraps 0xFFFF->0
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-high.
//   Reset: all outputs 0, FSM=IDLE, rate/timeout counters 0. Wins over all inputs.
//   States: IDLE, WAIT_TICK, START_V, CONV_V, START_I, CONV_I, PUBLISH.
//   IDLE: enable=1 -> load rate_cnt=RATE_DIV-1, go WAIT_TICK.
//   rate_cnt: while not IDLE, decrements each cycle; tick at 0, reloads RATE_DIV-1.
//   WAIT_TICK: enable=0 -> IDLE; tick -> START_V.
//   START_x: adc_start=1, adc_chan=x for that one cycle; clear tmo_cnt; -> CONV_x.
//   CONV_x: adc_done=1 -> capture adc_data; CONV_V->START_I, CONV_I->PUBLISH.
//     No done: tmo_cnt++; no done by cycle CONV_TIMEOUT -> timeout_err=1,
//     pair aborted (no strobe, outputs unchanged), -> WAIT_TICK.
//   adc_done outside CONV_x ignored (incl. cycle of adc_start).
//   PUBLISH: vdd/idd_sample update, sample_valid=1, pair_cnt++ same cycle;
//     -> WAIT_TICK if enable=1 else IDLE.
//   Latency: tick cycle T -> adc_start(V) T+1; done(V) at D1 -> adc_start(I)
//     D1+1; done(I) at D2 -> sample_valid at D2+1.
//   Overrun: tick while seq_busy=1 -> tick dropped, overrun_cnt++ (sat 255).
//   enable=0 mid-pair: pair completes (or times out), then IDLE.
//   timeout_err: set and timeout_clr same cycle -> set wins.
// CONFIGURATION
//   KAVACH_ADC_OVS_EN defined: each channel runs 2^OVS_LOG2 START/CONV rounds,
//     summed in ADC_WIDTH+OVS_LOG2-bit accumulator cleared at START_V/START_I
//     entry; output = accum>>OVS_LOG2 (truncate). Any round timeout aborts pair.
//   Undefined: one conversion per channel, OVS_LOG2 ignored, no accumulator.
// TESTING
//   1 RATE_DIV=16, ADC done 3 cyc after start, V=2048 I=1024 -> strobe every 16
//     cyc, vdd=2048 idd=1024, adc_chan 0 then 1, pair_cnt +1 per strobe.
//   2 IDD done never asserted, CONV_TIMEOUT=64 -> timeout_err=1 after 64 CONV_I
//     cycles, no strobe; next tick retries; timeout_clr -> timeout_err=0.
//   3 RATE_DIV=16, done latency 20 -> overrun_cnt +1 per dropped tick, holds 255.
//   4 rst=1 mid CONV_I -> next cycle all outputs 0, FSM IDLE, no strobe.
//   5 KAVACH_ADC_OVS_EN, OVS_LOG2=2, V=2048,2049,2050,2051 -> vdd_sample=2049.
//   6 enable=0 during CONV_V -> one strobe, then no adc_start, seq_busy=0.

Source files
------------

// File: rtl/kavach_adc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  kavach_adc_sequencer_if : ADC start/done handshake plus VDD/IDD sample bus
//  Revision: 1.0
// ============================================================================
interface kavach_adc_sequencer_if #(
  parameter int ADC_WIDTH = 12
);
  logic                 adc_start;
  logic                 adc_chan;
  logic                 adc_done;
  logic [ADC_WIDTH-1:0] adc_data;
  logic [ADC_WIDTH-1:0] vdd_sample;
  logic [ADC_WIDTH-1:0] idd_sample;
  logic                 sample_valid;

  modport master (
    output adc_start, adc_chan, vdd_sample, idd_sample, sample_valid,
    input  adc_done, adc_data
  );

  modport slave (
    input  adc_start, adc_chan, vdd_sample, idd_sample, sample_valid,
    output adc_done, adc_data
  );
endinterface
`default_nettype wire

// File: rtl/kavach_adc_sequencer.sv
`default_nettype none
// ============================================================================
//  kavach_adc_sequencer : paces the ADC through VDD then IDD conversions per
//  tick and publishes the pair; KAVACH_ADC_OVS_EN enables oversampling.
//  Revision: 1.0
// ============================================================================
module kavach_adc_sequencer #(
  parameter int          ADC_WIDTH    = 12,
  parameter logic [15:0] RATE_DIV     = 16'd100,
  parameter logic [7:0]  CONV_TIMEOUT = 8'd64
`ifdef KAVACH_ADC_OVS_EN
  , parameter int        OVS_LOG2     = 2
`endif
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              enable,
  kavach_adc_sequencer_if.master adc_if,
  output logic                   seq_busy,
  output logic                   timeout_err,
  input  wire logic              timeout_clr,
  output logic [7:0]             overrun_cnt,
  output logic [15:0]            pair_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_START_V   = 3'd2,
    S_CONV_V    = 3'd3,
    S_START_I   = 3'd4,
    S_CONV_I    = 3'd5,
    S_PUBLISH   = 3'd6
  } state_t;

  localparam logic [15:0] c_RATE_RELOAD = RATE_DIV - 16'd1;
  localparam logic [7:0]  c_TMO_LAST    = CONV_TIMEOUT - 8'd1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [15:0]          r_rate_cnt;
  logic [7:0]           r_tmo_cnt;
  logic [ADC_WIDTH-1:0] r_vdd_cap;
  logic [ADC_WIDTH-1:0] r_vdd_sample;
  logic [ADC_WIDTH-1:0] r_idd_sample;
  logic                 r_sample_valid;
  logic                 r_timeout_err;
  logic [7:0]           r_overrun_cnt;
  logic [15:0]          r_pair_cnt;

  logic                 w_tick;
  logic                 w_conv;
  logic                 w_done;
  logic                 w_tmo_expire;
  logic                 w_last_round;
  logic [ADC_WIDTH-1:0] w_result;
  logic                 w_adc_start;
  logic                 w_adc_chan;
  logic                 w_busy;

  assign w_tick       = (r_state != S_IDLE) && (r_rate_cnt == 16'd0);
  assign w_conv       = (r_state == S_CONV_V) || (r_state == S_CONV_I);
  assign w_done       = w_conv && adc_if.adc_done;
  assign w_tmo_expire = w_conv && !adc_if.adc_done && (r_tmo_cnt == c_TMO_LAST);

`ifdef KAVACH_ADC_OVS_EN
  localparam int                c_ACC_W      = ADC_WIDTH + OVS_LOG2;
  localparam logic [OVS_LOG2:0] c_LAST_ROUND = (OVS_LOG2 + 1)'((1 << OVS_LOG2) - 1);

  logic [OVS_LOG2:0] r_round;
  logic [c_ACC_W-1:0] r_accum;
  logic [c_ACC_W-1:0] w_accum_sum;

  assign w_accum_sum  = r_accum + c_ACC_W'(adc_if.adc_data);
  assign w_last_round = (r_round == c_LAST_ROUND);
  assign w_result     = ADC_WIDTH'(w_accum_sum >> OVS_LOG2);

  // Accumulator restarts at zero for each channel and after any abort
  always_ff @(posedge clk) begin
    if (rst) begin
      r_round <= '0;
      r_accum <= '0;
    end else if (w_done && !w_last_round) begin
      r_round <= r_round + 1'b1;
      r_accum <= w_accum_sum;
    end else if (w_done || w_tmo_expire) begin
      r_round <= '0;
      r_accum <= '0;
    end
  end
`else
  assign w_last_round = 1'b1;
  assign w_result     = adc_if.adc_data;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_adc_start = 1'b0;
    w_adc_chan  = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (enable) w_state_nxt = S_WAIT_TICK;
      end
      S_WAIT_TICK: begin
        w_busy = 1'b0;
        if (!enable)     w_state_nxt = S_IDLE;
        else if (w_tick) w_state_nxt = S_START_V;
      end
      S_START_V: begin
        w_adc_start = 1'b1;
        w_state_nxt = S_CONV_V;
      end
      S_CONV_V: begin
        if (adc_if.adc_done) w_state_nxt = w_last_round ? S_START_I : S_START_V;
        else if (w_tmo_expire) w_state_nxt = S_WAIT_TICK;
      end
      S_START_I: begin
        w_adc_start = 1'b1;
        w_adc_chan  = 1'b1;
        w_state_nxt = S_CONV_I;
      end
      S_CONV_I: begin
        w_adc_chan = 1'b1;
        if (adc_if.adc_done) w_state_nxt = w_last_round ? S_PUBLISH : S_START_I;
        else if (w_tmo_expire) w_state_nxt = S_WAIT_TICK;
      end
      S_PUBLISH: begin
        w_state_nxt = enable ? S_WAIT_TICK : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_rate_cnt     <= 16'd0;
      r_tmo_cnt      <= 8'd0;
      r_vdd_cap      <= '0;
      r_vdd_sample   <= '0;
      r_idd_sample   <= '0;
      r_sample_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_overrun_cnt  <= 8'd0;
      r_pair_cnt     <= 16'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_sample_valid <= 1'b0;

      if (r_state == S_IDLE) begin
        if (enable) r_rate_cnt <= c_RATE_RELOAD;
      end else if (w_tick) begin
        r_rate_cnt <= c_RATE_RELOAD;
      end else begin
        r_rate_cnt <= r_rate_cnt - 16'd1;
      end

      if (w_tick && w_busy && (r_overrun_cnt != 8'hFF))
        r_overrun_cnt <= r_overrun_cnt + 8'd1;

      if (w_adc_start)                     r_tmo_cnt <= 8'd0;
      else if (w_conv && !adc_if.adc_done) r_tmo_cnt <= r_tmo_cnt + 8'd1;

      if (w_tmo_expire)     r_timeout_err <= 1'b1;
      else if (timeout_clr) r_timeout_err <= 1'b0;

      if (w_done && w_last_round && (r_state == S_CONV_V))
        r_vdd_cap <= w_result;

      // Outputs are loaded on the final IDD done so they appear with the PUBLISH cycle
      if (w_done && w_last_round && (r_state == S_CONV_I)) begin
        r_vdd_sample   <= r_vdd_cap;
        r_idd_sample   <= w_result;
        r_sample_valid <= 1'b1;
        r_pair_cnt     <= r_pair_cnt + 16'd1;
      end
    end
  end

  assign adc_if.adc_start    = w_adc_start;
  assign adc_if.adc_chan     = w_adc_chan;
  assign adc_if.vdd_sample   = r_vdd_sample;
  assign adc_if.idd_sample   = r_idd_sample;
  assign adc_if.sample_valid = r_sample_valid;
  assign seq_busy            = w_busy;
  assign timeout_err         = r_timeout_err;
  assign overrun_cnt         = r_overrun_cnt;
  assign pair_cnt            = r_pair_cnt;

endmodule
`default_nettype wire

// File: tb/tb_kavach_adc_sequencer.sv
`default_nettype none
// ============================================================================
//  tb_kavach_adc_sequencer : directed stimulus, behavioural ADC, scoreboard
//  Revision: 1.0
// ============================================================================
module tb_kavach_adc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        timeout_clr;
  logic        seq_busy;
  logic        timeout_err;
  logic [7:0]  overrun_cnt;
  logic [15:0] pair_cnt;

  kavach_adc_sequencer_if #(.ADC_WIDTH(12)) bus ();

  kavach_adc_sequencer #(
    .ADC_WIDTH    (12),
    .RATE_DIV     (16'd16),
    .CONV_TIMEOUT (8'd64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .adc_if      (bus),
    .seq_busy    (seq_busy),
    .timeout_err (timeout_err),
    .timeout_clr (timeout_clr),
    .overrun_cnt (overrun_cnt),
    .pair_cnt    (pair_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] vdd;
    logic [11:0] idd;
    logic [15:0] pair;
    int          gap;
    bit          chk_ovr;
    logic [7:0]  ovr;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_strobe = 0;

  // ADC model settings
  int          lat        = 3;
  logic [11:0] val_v      = 12'd0;
  logic [11:0] val_i      = 12'd0;
  bit          suppress_i = 1'b0;
  bit          ovs_ramp   = 1'b0;
  int          pend_cnt   = 0;
  logic        pend_chan  = 1'b0;
  int          v_idx      = 0;
  int          starts     = 0;
  logic        chan_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [11:0] v, input logic [11:0] i, input logic [15:0] p,
                          input int gap, input bit chk_o, input logic [7:0] o);
    exp_t e;
    e.vdd = v; e.idd = i; e.pair = p; e.gap = gap; e.chk_ovr = chk_o; e.ovr = o;
    sb.push_back(e);
  endtask

  always @(posedge clk) cyc++;

  // Behavioural ADC: done exactly lat cycles after the start cycle
  always @(negedge clk) begin
    bus.adc_done = 1'b0;
    if (rst) begin
      pend_cnt = 0;
      v_idx    = 0;
      starts   = 0;
      chan_log.delete();
      bus.adc_data = 12'd0;
    end else begin
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0 && !(pend_chan && suppress_i)) begin
          bus.adc_done = 1'b1;
          if (pend_chan) bus.adc_data = val_i;
          else begin
            bus.adc_data = val_v + (ovs_ramp ? 12'(v_idx % 4) : 12'd0);
            v_idx++;
          end
        end
      end
      if (bus.adc_start) begin
        pend_chan = bus.adc_chan;
        pend_cnt  = lat;
        starts++;
        chan_log.push_back(bus.adc_chan);
      end
    end
  end

  // Monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.sample_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'(pair_cnt), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("vdd_sample", 32'(bus.vdd_sample), 32'(e.vdd));
        chk("idd_sample", 32'(bus.idd_sample), 32'(e.idd));
        chk("pair_cnt",   32'(pair_cnt),       32'(e.pair));
        if (e.gap != 0)  chk("strobe_gap", 32'(cyc - last_strobe), 32'(e.gap));
        if (e.chk_ovr)   chk("overrun_cnt", 32'(overrun_cnt), 32'(e.ovr));
      end
      last_strobe = cyc;
    end
  end

  task automatic wait_sb(input int budget, input string nm);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_start(input logic chan, input int budget, input string nm);
    int n = 0;
    while (!(bus.adc_start && bus.adc_chan == chan) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(bus.adc_start && bus.adc_chan == chan), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    timeout_clr = 1'b0;
    suppress_i = 1'b0;
    ovs_ramp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] out_vec();
    return {bus.adc_start, bus.adc_chan, bus.sample_valid, seq_busy, timeout_err, 27'd0} |
           32'(bus.vdd_sample) | 32'(bus.idd_sample) | 32'(overrun_cnt) | 32'(pair_cnt);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    timeout_clr = 1'b0;
    do_reset();
    chk("reset_outputs", out_vec(), 32'd0);
    chk("reset_busy", 32'(seq_busy), 32'd0);

`ifdef KAVACH_ADC_OVS_EN
    // Oversampled: four VDD rounds 2048..2051 average to 2049
    lat = 2; val_v = 12'd2048; val_i = 12'd1024; ovs_ramp = 1'b1;
    push_exp(12'd2049, 12'd1024, 16'd1, 0, 1'b0, 8'd0);
    push_exp(12'd2049, 12'd1024, 16'd2, 0, 1'b0, 8'd0);
    enable = 1'b1;
    wait_sb(400, "ovs_pairs");
    enable = 1'b0;
`else
    // Basic pacing, two data patterns, 16-cycle strobe period
    lat = 3; val_v = 12'd2048; val_i = 12'd1024;
    push_exp(12'd2048, 12'd1024, 16'd1, 0,  1'b0, 8'd0);
    push_exp(12'd2048, 12'd1024, 16'd2, 16, 1'b0, 8'd0);
    push_exp(12'd2048, 12'd1024, 16'd3, 16, 1'b0, 8'd0);
    enable = 1'b1;
    wait_sb(200, "basic_pairs");
    for (int i = 0; i < 6; i++)
      chk("chan_order", (i < chan_log.size()) ? 32'(chan_log[i]) : 32'hDEAD, 32'(i % 2));
    val_v = 12'hFFF; val_i = 12'h001;
    push_exp(12'hFFF, 12'h001, 16'd4, 16, 1'b0, 8'd0);
    push_exp(12'hFFF, 12'h001, 16'd5, 16, 1'b0, 8'd0);
    wait_sb(100, "pattern2_pairs");
    chk("overrun_none", 32'(overrun_cnt), 32'd0);

    // IDD never completes: timeout after 64 CONV_I cycles, then retry and clear
    do_reset();
    lat = 3; val_v = 12'h800; val_i = 12'h400; suppress_i = 1'b1;
    enable = 1'b1;
    wait_start(1'b1, 100, "tmo_start_i");
    repeat (64) @(negedge clk);
    chk("tmo_not_yet", 32'(timeout_err), 32'd0);
    @(negedge clk);
    chk("tmo_set", 32'(timeout_err), 32'd1);
    chk("tmo_idle_busy", 32'(seq_busy), 32'd0);
    chk("tmo_overruns", 32'(overrun_cnt), 32'd4);
    chk("tmo_no_pair", 32'(pair_cnt), 32'd0);
    suppress_i = 1'b0;
    push_exp(12'h800, 12'h400, 16'd1, 0, 1'b0, 8'd0);
    wait_start(1'b0, 20, "tmo_retry");
    wait_sb(60, "tmo_retry_pair");
    chk("tmo_sticky", 32'(timeout_err), 32'd1);
    timeout_clr = 1'b1;
    @(negedge clk);
    timeout_clr = 1'b0;
    chk("tmo_cleared", 32'(timeout_err), 32'd0);
    enable = 1'b0;

    // Slow ADC: two dropped ticks per pair, counter saturates at 255
    do_reset();
    lat = 20; val_v = 12'h123; val_i = 12'h456;
    for (int k = 1; k <= 130; k++) begin
      bit c;
      c = (k <= 2) || (k >= 127);
      push_exp(12'h123, 12'h456, 16'(k), (k == 1) ? 0 : 48, c,
               (2 * k > 255) ? 8'd255 : 8'(2 * k));
    end
    enable = 1'b1;
    wait_sb(6600, "overrun_pairs");
    chk("overrun_sat", 32'(overrun_cnt), 32'd255);
    enable = 1'b0;

    // Reset in the middle of CONV_I
    do_reset();
    lat = 4; val_v = 12'h0AA; val_i = 12'h055;
    push_exp(12'h0AA, 12'h055, 16'd1, 0, 1'b0, 8'd0);
    enable = 1'b1;
    wait_sb(100, "rst_first_pair");
    wait_start(1'b1, 40, "rst_start_i");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", out_vec(), 32'd0);
    chk("rst_mid_busy", 32'(seq_busy), 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_no_starts", 32'(starts), 32'd0);
    chk("rst_pair_cnt", 32'(pair_cnt), 32'd0);

    // enable drops during CONV_V: current pair still publishes, then stop
    do_reset();
    lat = 3; val_v = 12'h321; val_i = 12'h654;
    push_exp(12'h321, 12'h654, 16'd1, 0, 1'b0, 8'd0);
    enable = 1'b1;
    wait_start(1'b0, 40, "dis_start_v");
    @(negedge clk);
    enable = 1'b0;
    wait_sb(40, "dis_pair");
    begin
      int snap;
      snap = starts;
      repeat (30) @(negedge clk);
      chk("dis_no_start", 32'(starts - snap), 32'd0);
    end
    chk("dis_busy", 32'(seq_busy), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
